// File: rtl/step_sequencer.sv
// step_sequencer: instruction fetch / step counter for a multi-cycle controller.
// T walks 0 -> 1 -> 2 -> 3 under an advance enable (free-run or a single-step
// button edge). T = 0 is the fetch slot; T = 1..3 is the execution window,
// ended early by Clr. Running past T = 3 without Clr raises a sticky err.
module step_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       IRin,
    input  logic       Clr,
    input  logic       run,
    input  logic       step,
    output logic [9:0] INSTR,
    output logic [1:0] T,
    output logic       busy,
    output logic [7:0] instr_count,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_T0 = 2'd0,
        ST_T1 = 2'd1,
        ST_T2 = 2'd2,
        ST_T3 = 2'd3
    } tstep_e;

    tstep_e     t_q, t_d;
    logic [9:0] instr_q, instr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       step_q, step_d;

    logic       step_rise;
    logic       adv;
    logic       fetch;

    // Advance enable: free-run, or one pulse per rising edge of the button
    always_comb begin
        step_d    = step;
        step_rise = step & ~step_q;
        adv       = run | step_rise;
        fetch     = adv & (t_q == ST_T0) & IRin & din_valid;
        // Reset masks the handshake so no instruction is consumed while held
        din_ready = fetch & ~rst;
    end

    // Next-state logic for the step counter, instruction register and status
    always_comb begin
        t_d     = t_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (adv) begin
            case (t_q)
                ST_T0: begin
                    // Clr is meaningless in the fetch slot and is ignored
                    if (IRin && din_valid) begin
                        instr_d = din;
                        t_d     = ST_T1;
                    end
                end
                ST_T1: begin
                    if (Clr) begin
                        t_d   = ST_T0;
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        t_d = ST_T2;
                    end
                end
                ST_T2: begin
                    if (Clr) begin
                        t_d   = ST_T0;
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        t_d = ST_T3;
                    end
                end
                ST_T3: begin
                    if (Clr) begin
                        t_d   = ST_T0;
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        // Overrun: controller never finished; abandon and flag
                        t_d   = ST_T0;
                        err_d = 1'b1;
                    end
                end
                default: t_d = ST_T0;
            endcase
        end
    end

    // State registers; synchronous reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            t_q     <= ST_T0;
            instr_q <= 10'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            t_q     <= t_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            step_q  <= step_d;
        end
    end

    assign T           = t_q;
    assign INSTR       = instr_q;
    assign instr_count = cnt_q;
    assign err         = err_q;
    assign busy        = (t_q != ST_T0);

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port din, input, 10 bits: external instruction bus.
REQ-004 SHALL have port din_valid, input, 1 bit: din holds a valid instruction.
REQ-005 SHALL have port din_ready, output, 1 bit: instruction accepted this cycle.
REQ-006 SHALL have port IRin, input, 1 bit: instruction-register load request from the controller.
REQ-007 SHALL have port Clr, input, 1 bit: end-of-instruction from the controller.
REQ-008 SHALL have port run, input, 1 bit: 1 = free-running, 0 = single-step mode.
REQ-009 SHALL have port step, input, 1 bit: level from a push-button, already synchronised to clk.
REQ-010 SHALL have port INSTR, output, 10 bits: instruction register contents, fed to the controller.
REQ-011 SHALL have port T, output, 2 bits: current step count, fed to the controller.
REQ-012 SHALL have port busy, output, 1 bit: 1 while T != 0.
REQ-013 SHALL have port instr_count, output, 8 bits: number of completed instructions.
REQ-014 SHALL have port err, output, 1 bit: sticky step-overrun flag.

Function
REQ-015 SHALL define an advance enable adv = run OR step_rise, where step_rise = step AND NOT step_q and step_q is step registered on clk.
REQ-016 SHALL leave T, INSTR, instr_count and err unchanged on any cycle with adv = 0, and SHALL hold din_ready at 0 on those cycles.
REQ-017 SHALL, when T = 0, adv = 1, IRin = 1 and din_valid = 1: load INSTR <= din, assert din_ready combinationally that cycle, and set T <= 1.
REQ-018 SHALL, when T = 0 and (din_valid = 0 or IRin = 0): hold T at 0 (fetch stall) with din_ready = 0.
REQ-019 SHALL ignore Clr while T = 0.
REQ-020 SHALL, when T is 1, 2 or 3, adv = 1 and Clr = 1: set T <= 0 and increment instr_count by 1 modulo 256 (255 wraps to 0, no flag).
REQ-021 SHALL, when T is 1 or 2, adv = 1 and Clr = 0: set T <= T + 1.
REQ-022 SHALL, when T = 3, adv = 1 and Clr = 0: set T <= 0, set err <= 1, and leave instr_count unchanged.
REQ-023 SHALL hold err at 1 until the next reset; a later Clr SHALL NOT clear it.
REQ-024 SHALL change INSTR only under REQ-017, so INSTR is stable for the whole execution window T = 1..3.
REQ-025 SHALL assert din_ready for exactly one cycle per accepted instruction; a din_valid held high SHALL NOT be accepted again until the next T = 0 cycle with adv = 1.
REQ-026 SHALL drive busy = (T != 0) combinationally.
REQ-027 SHALL count a step held high for N cycles as one advance (one rising edge gives one adv pulse).

Reset
REQ-028 SHALL, when rst = 1 at a clock edge, set T = 0, INSTR = 0, instr_count = 0, err = 0 and step_q = 0; rst SHALL override every other input.
REQ-029 SHALL drive din_ready = 0 during any cycle with rst = 1.
REQ-030 SHALL abandon an instruction in progress when reset mid-instruction (T = 1..3), with no instr_count increment and no err.

Verification
REQ-031 SHALL pass this scenario: run = 1, din = 10'h0C5, din_valid = 1, IRin = 1 at T = 0 -> din_ready pulses once; INSTR = 10'h0C5 and T = 1 next cycle; T = 2, then Clr at T = 3 -> T = 0, instr_count = 1.
REQ-032 SHALL pass this scenario: run = 1, din_valid = 0 for 5 cycles -> T stays 0, din_ready = 0, busy = 0.
REQ-033 SHALL pass this scenario: run = 1, Clr never asserted after fetch -> T sequence 1, 2, 3, 0; err = 1 and stays 1 through a following normal instruction; instr_count unchanged by the overrun.
REQ-034 SHALL pass this scenario: run = 0, step held high 4 cycles, then low, then high 1 cycle -> exactly two advances (T 0->1->2, given a valid fetch).
REQ-035 SHALL pass this scenario: instr_count = 255 and Clr at T = 2 -> instr_count = 0, T = 0.
REQ-036 SHALL pass this scenario: rst asserted at T = 2 with INSTR = 10'h3FF -> next cycle T = 0, INSTR = 0, instr_count and err = 0.
